fifo_sync_param: RTL and testbench
==================================

# fifo_sync_param

Parametrised single-clock FIFO, the next generation of the basic design FIFO, for buffering between the CPU, the UART and the memory-mapped peripherals. It supports any depth including non-power-of-two, a registered or first-word-fall-through read mode, an occupancy count, and programmable almost-full/almost-empty flags. It also has a synchronous flush and sticky overflow/underflow error flags, so producers and consumers can use it without external bookkeeping.

## Interface
- WIDTH, 32, data word width in bits (>=1)
- DEPTH, 16, number of entries (>=2, any integer)
- FWFT, 0, 0 = registered read mode; 1 = first-word-fall-through mode
- AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL
- CLOCK_50  in  1  clock; all logic on rising edge
- RST_N  in  1  reset, synchronous, active-low
- flush  in  1  discard all contents this cycle
- data_in  in  WIDTH  write data
- write  in  1  write request
- read  in  1  read request (FWFT: pop head)
- clr_err  in  1  clear sticky overflow/underflow
- data_out  out  WIDTH  read data
- data_valid  out  1  mode 0: one-cycle pulse, data_out newly loaded; mode 1: equals ~empty
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full and not accepted
- underflow  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH x WIDTH array. Read and write pointers are $clog2(DEPTH) bits wide (1 bit minimum). Each pointer wraps from DEPTH-1 to 0 explicitly, never by natural overflow. count is held in its own register of full width.
- Accept rules, evaluated on pre-edge state:
  - wr_ok = write & (~full | rd_ok)
  - rd_ok = read & ~empty
- A simultaneous read and write while full: both accepted, count unchanged, data_in stored in the slot freed by the read.
- A simultaneous read and write while empty: write accepted, read rejected, underflow set.
- count update: next = count + wr_ok - rd_ok, single adder, no separate assignments that can shadow each other.
- Mode 0: on rd_ok, data_out <= mem[rd_ptr] and data_valid = 1 for the next cycle. Otherwise data_out holds and data_valid = 0.
- Mode 1: data_out = mem[rd_ptr] combinationally, and is only meaningful while ~empty. read pops the head, and the next entry appears after the edge.
- Errors:
  - write & ~wr_ok sets overflow; read & empty sets underflow.
  - Both are sticky until clr_err or reset.
  - If clr_err and a new error occur in the same cycle, the flag stays set.
- Flush: pointers and count go to 0 and data_valid to 0. Flush overrides read/write in the same cycle, which are ignored with no error flagged. data_out holds. Memory contents are not cleared.
- Reset (RST_N = 0 at edge) overrides everything: pointers, count, data_out, data_valid, overflow and underflow all go to 0. Memory contents are not cleared.

## Timing
- Reset values: data_out = 0, data_valid = 0, empty = 1, full = 0, almost_empty = 1, almost_full = (AF_LEVEL == 0), count = 0, overflow = 0, underflow = 0.
- All flags are decoded combinationally from registered count and change only after a clock edge.
- Write latency: a word written at edge N is readable from edge N+1 (mode 1: visible on data_out after edge N when the FIFO was empty).
- Mode 0 read latency: read at edge N gives data_out and data_valid valid in the cycle after edge N.
- Throughput: one write and one read per cycle sustained.
- Reset mid-operation discards all in-flight data. The first write after reset lands at address 0.

## Test plan
- Reset, then 16 writes of 0x100..0x10F (DEPTH=16) -> full=1 and count=16 after the 16th edge; a 17th write sets overflow=1 and count stays 16; 16 reads return 0x100..0x10F in order; afterwards empty=1.
- DEPTH=10: 25 interleaved write/read pairs with an incrementing pattern -> pointer wrap at 9->0 verified, data order preserved, count never exceeds 10.
- Simultaneous read+write when full (count=16) -> count stays 16, oldest word out, new word at tail. Simultaneous read+write when empty -> count=1, underflow=1, data_valid=0.
- FWFT=1: write 0xA5 into empty FIFO -> data_out=0xA5 and data_valid=1 the cycle after; read -> empty=1 next cycle.
- AF_LEVEL=14, AE_LEVEL=2: fill one word at a time -> almost_empty drops at count=3 and almost_full rises at count=14; then clr_err clears overflow.
- Flush with count=7 while write=1 -> count=0, empty=1, the written word is discarded, no error flags. Mid-stream RST_N low for one cycle -> all outputs match the reset values.

Source files
------------

// File: rtl/fifo_sync_param_if.sv
// Handshake/data bundle between a producer/consumer (master) and fifo_sync_param (slave).
// The count width tracks DEPTH so it can hold the full occupancy 0..DEPTH.
interface fifo_sync_param_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             flush;
    logic [WIDTH-1:0] data_in;
    logic             write;
    logic             read;
    logic             clr_err;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, data_in, write, read, clr_err,
        input  data_out, data_valid, empty, full, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, data_in, write, read, clr_err,
        output data_out, data_valid, empty, full, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO of any depth with registered or first-word-fall-through read,
// occupancy count, programmable almost flags, synchronous flush and sticky error flags.
module fifo_sync_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input logic                 CLOCK_50,
    input logic                 RST_N,
    fifo_sync_param_if.slave    bus
);
    localparam int PTR_W = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] dataOut_q, dataOut_d;
    logic             dataValid_q, dataValid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic emptyFlag, fullFlag, rdOk, wrOk;

    assign emptyFlag = (count_q == '0);
    assign fullFlag  = (count_q == DEPTH_C);
    // A read frees a slot in the same edge, so a full FIFO can still take a write.
    assign rdOk      = bus.read & ~emptyFlag;
    assign wrOk      = bus.write & (~fullFlag | rdOk);

    always_comb begin
        rdPtr_d     = rdPtr_q;
        wrPtr_d     = wrPtr_q;
        count_d     = count_q;
        dataOut_d   = dataOut_q;
        dataValid_d = 1'b0;
        overflow_d  = overflow_q & ~bus.clr_err;
        underflow_d = underflow_q & ~bus.clr_err;
        if (bus.flush) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (rdOk) begin
                rdPtr_d     = (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + 1'b1;
                dataOut_d   = mem[rdPtr_q];
                dataValid_d = 1'b1;
            end
            if (wrOk) begin
                wrPtr_d = (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + 1'b1;
            end
            count_d     = count_q + CNT_W'(wrOk) - CNT_W'(rdOk);
            overflow_d  = overflow_d | (bus.write & ~wrOk);
            underflow_d = underflow_d | (bus.read & emptyFlag);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
            rdPtr_q     <= '0;
            wrPtr_q     <= '0;
            count_q     <= '0;
            dataOut_q   <= '0;
            dataValid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rdPtr_q     <= rdPtr_d;
            wrPtr_q     <= wrPtr_d;
            count_q     <= count_d;
            dataOut_q   <= dataOut_d;
            dataValid_q <= dataValid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage has no reset; stale words are unreachable once the pointers are cleared.
    always_ff @(posedge CLOCK_50) begin
        if (RST_N && !bus.flush && wrOk) begin
            mem[wrPtr_q] <= bus.data_in;
        end
    end

    assign bus.data_out     = (FWFT != 0) ? mem[rdPtr_q] : dataOut_q;
    assign bus.data_valid   = (FWFT != 0) ? ~emptyFlag : dataValid_q;
    assign bus.empty        = emptyFlag;
    assign bus.full         = fullFlag;
    assign bus.almost_full  = (int'(count_q) >= AF_LEVEL);
    assign bus.almost_empty = (int'(count_q) <= AE_LEVEL);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench: a registered-read FIFO (DEPTH 16) and a FWFT FIFO (DEPTH 10),
// both compared against queue-based reference models.
module tb_fifo_sync_param;
    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    fifo_sync_param_if #(.WIDTH(32), .DEPTH(16)) busA ();
    fifo_sync_param_if #(.WIDTH(32), .DEPTH(10)) busB ();

    fifo_sync_param #(.WIDTH(32), .DEPTH(16), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)) dutA (
        .CLOCK_50(clk), .RST_N(rstN), .bus(busA)
    );
    fifo_sync_param #(.WIDTH(32), .DEPTH(10), .FWFT(1), .AF_LEVEL(8), .AE_LEVEL(2)) dutB (
        .CLOCK_50(clk), .RST_N(rstN), .bus(busB)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] qA[$];
    logic [31:0] qB[$];
    logic [31:0] mAOut;
    logic        mAVal, mAOvf, mAUnf, mBOvf, mBUnf;

    task automatic modelReset();
        qA.delete();
        qB.delete();
        mAOut = '0;
        mAVal = 1'b0;
        mAOvf = 1'b0;
        mAUnf = 1'b0;
        mBOvf = 1'b0;
        mBUnf = 1'b0;
    endtask

    task automatic doReset();
        rstN = 1'b0;
        @(posedge clk);
        modelReset();
        #1 rstN = 1'b1;
    endtask

    // Expected {count, empty, full, almost_full, almost_empty, overflow, underflow, data_valid}
    function automatic logic [11:0] expStatA();
        int n = qA.size();
        return {5'(n), n == 0, n == 16, n >= 14, n <= 2, mAOvf, mAUnf, mAVal};
    endfunction

    function automatic logic [10:0] expStatB();
        int n = qB.size();
        return {4'(n), n == 0, n == 10, n >= 8, n <= 2, mBOvf, mBUnf, n != 0};
    endfunction

    function automatic logic [11:0] actStatA();
        return {busA.count, busA.empty, busA.full, busA.almost_full, busA.almost_empty,
                busA.overflow, busA.underflow, busA.data_valid};
    endfunction

    function automatic logic [10:0] actStatB();
        return {busB.count, busB.empty, busB.full, busB.almost_full, busB.almost_empty,
                busB.overflow, busB.underflow, busB.data_valid};
    endfunction

    task automatic stepA(input logic w, input logic r, input logic f, input logic c,
                         input logic [31:0] d);
        logic rdok, wrok, newO, newU;
        busA.write = w; busA.read = r; busA.flush = f; busA.clr_err = c; busA.data_in = d;
        @(posedge clk);
        newO = 1'b0;
        newU = 1'b0;
        if (f) begin
            qA.delete();
            mAVal = 1'b0;
        end else begin
            rdok = r && (qA.size() > 0);
            wrok = w && ((qA.size() < 16) || rdok);
            newO = w && !wrok;
            newU = r && (qA.size() == 0);
            mAVal = rdok;
            if (rdok) mAOut = qA.pop_front();
            if (wrok) qA.push_back(d);
        end
        mAOvf = (mAOvf && !c) || newO;
        mAUnf = (mAUnf && !c) || newU;
        #1;
        busA.write = 1'b0; busA.read = 1'b0; busA.flush = 1'b0; busA.clr_err = 1'b0;
    endtask

    task automatic stepB(input logic w, input logic r, input logic f, input logic c,
                         input logic [31:0] d);
        logic rdok, wrok, newO, newU;
        busB.write = w; busB.read = r; busB.flush = f; busB.clr_err = c; busB.data_in = d;
        @(posedge clk);
        newO = 1'b0;
        newU = 1'b0;
        if (f) begin
            qB.delete();
        end else begin
            rdok = r && (qB.size() > 0);
            wrok = w && ((qB.size() < 10) || rdok);
            newO = w && !wrok;
            newU = r && (qB.size() == 0);
            if (rdok) void'(qB.pop_front());
            if (wrok) qB.push_back(d);
        end
        mBOvf = (mBOvf && !c) || newO;
        mBUnf = (mBUnf && !c) || newU;
        #1;
        busB.write = 1'b0; busB.read = 1'b0; busB.flush = 1'b0; busB.clr_err = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if (actStatA() !== 12'b00000_1_0_0_1_0_0_0) begin
            errors++;
            $display("[TB] FAIL reset_statusA: got %b expected %b", actStatA(), 12'b00000_1_0_0_1_0_0_0);
        end
        checks++;
        if (busA.data_out !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_doutA: got %h expected 00000000", busA.data_out);
        end
        checks++;
        if (actStatB() !== 11'b0000_1_0_0_1_0_0_0) begin
            errors++;
            $display("[TB] FAIL reset_statusB: got %b expected %b", actStatB(), 11'b0000_1_0_0_1_0_0_0);
        end
    endtask

    task automatic test_fill_drain();
        doReset();
        for (int i = 0; i < 16; i++) begin
            stepA(1'b1, 1'b0, 1'b0, 1'b0, 32'h100 + i);
            checks++;
            if (busA.count !== 5'(i + 1)) begin
                errors++;
                $display("[TB] FAIL fill_count: got %0d expected %0d", busA.count, i + 1);
            end
        end
        checks++;
        if (busA.full !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fill_full: got %b expected 1", busA.full);
        end
        stepA(1'b1, 1'b0, 1'b0, 1'b0, 32'h1FF);
        checks++;
        if (busA.overflow !== 1'b1 || busA.count !== 5'd16) begin
            errors++;
            $display("[TB] FAIL overflow_write: got ovf=%b count=%0d expected ovf=1 count=16",
                     busA.overflow, busA.count);
        end
        for (int i = 0; i < 16; i++) begin
            stepA(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            checks++;
            if (busA.data_out !== 32'h100 + i || busA.data_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL drain_data: got %h/%b expected %h/1",
                         busA.data_out, busA.data_valid, 32'h100 + i);
            end
        end
        checks++;
        if (busA.empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drain_empty: got %b expected 1", busA.empty);
        end
    endtask

    task automatic test_flags();
        doReset();
        for (int i = 1; i <= 17; i++) begin
            stepA(1'b1, 1'b0, 1'b0, 1'b0, $urandom);
            checks++;
            if (actStatA() !== expStatA()) begin
                errors++;
                $display("[TB] FAIL flags_fill%0d: got %b expected %b", i, actStatA(), expStatA());
            end
            if (i == 3 || i == 14) begin
                checks++;
                if (busA.almost_empty !== 1'b0 || busA.almost_full !== (i == 14)) begin
                    errors++;
                    $display("[TB] FAIL flags_edge%0d: got ae=%b af=%b expected ae=0 af=%b",
                             i, busA.almost_empty, busA.almost_full, i == 14);
                end
            end
        end
        stepA(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        checks++;
        if (busA.overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clr_with_error: got %b expected 1", busA.overflow);
        end
        stepA(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        checks++;
        if (busA.overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clr_err: got %b expected 0", busA.overflow);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] oldest;
        oldest = qA[0];
        stepA(1'b1, 1'b1, 1'b0, 1'b0, 32'hBEEF);
        checks++;
        if (busA.count !== 5'd16 || busA.data_out !== oldest || busA.overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rw_full: got count=%0d dout=%h ovf=%b expected 16 %h 0",
                     busA.count, busA.data_out, busA.overflow, oldest);
        end
        stepA(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        stepA(1'b1, 1'b1, 1'b0, 1'b0, 32'hCAFE);
        checks++;
        if (busA.count !== 5'd1 || busA.underflow !== 1'b1 || busA.data_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rw_empty: got count=%0d unf=%b dv=%b expected 1 1 0",
                     busA.count, busA.underflow, busA.data_valid);
        end
        stepA(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (busA.data_out !== 32'hCAFE) begin
            errors++;
            $display("[TB] FAIL rw_empty_data: got %h expected 0000cafe", busA.data_out);
        end
    endtask

    task automatic test_flush_and_midreset();
        doReset();
        for (int i = 0; i < 7; i++) stepA(1'b1, 1'b0, 1'b0, 1'b0, 32'h700 + i);
        stepA(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        stepA(1'b1, 1'b0, 1'b0, 1'b0, 32'h707);
        stepA(1'b1, 1'b0, 1'b1, 1'b0, 32'hDEAD);
        checks++;
        if (actStatA() !== 12'b00000_1_0_0_1_0_0_0 || busA.data_out !== 32'h700) begin
            errors++;
            $display("[TB] FAIL flush: got %b dout=%h expected %b dout=00000700",
                     actStatA(), busA.data_out, 12'b00000_1_0_0_1_0_0_0);
        end
        stepA(1'b1, 1'b0, 1'b0, 1'b0, 32'h77);
        stepA(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (busA.data_out !== 32'h77) begin
            errors++;
            $display("[TB] FAIL flush_after: got %h expected 00000077", busA.data_out);
        end
        for (int i = 0; i < 3; i++) stepA(1'b1, 1'b0, 1'b0, 1'b0, 32'h900 + i);
        stepA(1'b1, 1'b1, 1'b0, 1'b0, 32'h903);
        doReset();
        checks++;
        if (actStatA() !== 12'b00000_1_0_0_1_0_0_0 || busA.data_out !== 32'h0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got %b dout=%h expected %b dout=0",
                     actStatA(), busA.data_out, 12'b00000_1_0_0_1_0_0_0);
        end
        stepA(1'b1, 1'b0, 1'b0, 1'b0, 32'hAB);
        stepA(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (busA.data_out !== 32'hAB) begin
            errors++;
            $display("[TB] FAIL post_reset_data: got %h expected 000000ab", busA.data_out);
        end
    endtask

    task automatic test_wrap_fwft();
        doReset();
        for (int i = 0; i < 5; i++) stepB(1'b1, 1'b0, 1'b0, 1'b0, 32'h200 + i);
        for (int k = 0; k < 25; k++) begin
            stepB(1'b1, 1'b0, 1'b0, 1'b0, 32'h205 + k);
            stepB(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            checks++;
            if (actStatB() !== expStatB() || busB.data_out !== 32'h201 + k) begin
                errors++;
                $display("[TB] FAIL wrap%0d: got %b dout=%h expected %b dout=%h",
                         k, actStatB(), busB.data_out, expStatB(), 32'h201 + k);
            end
        end
    endtask

    task automatic test_fwft();
        doReset();
        stepB(1'b1, 1'b0, 1'b0, 1'b0, 32'hA5);
        checks++;
        if (busB.data_out !== 32'hA5 || busB.data_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fwft_show: got %h/%b expected 000000a5/1", busB.data_out, busB.data_valid);
        end
        stepB(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (busB.empty !== 1'b1 || busB.data_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fwft_pop: got empty=%b dv=%b expected 1 0", busB.empty, busB.data_valid);
        end
    endtask

    task automatic test_random();
        doReset();
        for (int i = 0; i < 400; i++) begin
            stepA($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5, $urandom);
            checks++;
            if (actStatA() !== expStatA() || busA.data_out !== mAOut) begin
                errors++;
                $display("[TB] FAIL randomA%0d: got %b dout=%h expected %b dout=%h",
                         i, actStatA(), busA.data_out, expStatA(), mAOut);
            end
        end
        for (int i = 0; i < 400; i++) begin
            stepB($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5, $urandom);
            checks++;
            if (actStatB() !== expStatB() || (qB.size() > 0 && busB.data_out !== qB[0])) begin
                errors++;
                $display("[TB] FAIL randomB%0d: got %b dout=%h expected %b head=%h",
                         i, actStatB(), busB.data_out, expStatB(), (qB.size() > 0) ? qB[0] : 32'h0);
            end
        end
    endtask

    initial begin
        rstN = 1'b0;
        busA.write = 1'b0; busA.read = 1'b0; busA.flush = 1'b0; busA.clr_err = 1'b0; busA.data_in = '0;
        busB.write = 1'b0; busB.read = 1'b0; busB.flush = 1'b0; busB.clr_err = 1'b0; busB.data_in = '0;
        modelReset();
        test_reset();
        test_fill_drain();
        test_flags();
        test_simultaneous();
        test_flush_and_midreset();
        test_wrap_fwft();
        test_fwft();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
